// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 frame processor.
// Holds the frame-processing FSM encoding, the byte-field positions inside
// the 40-bit controller frame, the double-dabble sizing constants, and a
// helper that computes the DHT11 modulo-256 checksum of a frame.
package dht11_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_CONV    = 3'd2;
    localparam logic [2:0] ST_PUBLISH = 3'd3;
    localparam logic [2:0] ST_REJECT  = 3'd4;

    // Frame byte fields (LSB position of each byte)
    localparam int FRAME_W      = 40;
    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CSUM_LSB     = 0;

    // Double-dabble sizing: 8 input bits, 3 BCD digits, 20-bit shift register
    localparam int BCD_ITER = 8;
    localparam int BCD_W    = 12;
    localparam int SHIFT_W  = BCD_W + BCD_ITER;

    // Sum of the four data bytes, truncated to 8 bits
    function automatic logic [7:0] frame_sum(input logic [FRAME_W-1:0] f);
        logic [7:0] s;
        s = f[HUM_INT_LSB +: 8] + f[HUM_DEC_LSB +: 8]
          + f[TEMP_INT_LSB +: 8] + f[TEMP_DEC_LSB +: 8];
        return s;
    endfunction

endpackage

// File: rtl/dht11_frame_processor_bcd.sv
// bin8_to_bcd_seq: one sequential 8-bit binary to 3-digit BCD converter
// (double-dabble). The caller pulses load once, then asserts step for
// BCD_ITER cycles; bcd then holds hundreds/tens/ones.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - load {12'h000, bin} into the shift register
//   step      - one add-3-then-shift iteration
//   bin       - 8-bit binary input
//   bcd       - 12-bit BCD result (upper bits of the shift register)
module bin8_to_bcd_seq
    import dht11_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [7:0]        bin,
    output logic [BCD_W-1:0]  bcd
);

    logic [SHIFT_W-1:0] shift_reg;
    logic [SHIFT_W-1:0] adj;

    // Binary part passes through unchanged; each BCD nibble >= 5 gets +3
    assign adj[BCD_ITER-1:0] = shift_reg[BCD_ITER-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BCD_W / 4; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = shift_reg[BCD_ITER + 4*gi +: 4];
            assign adj[BCD_ITER + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= {{BCD_W{1'b0}}, bin};
        end else if (step) begin
            shift_reg <= {adj[SHIFT_W-2:0], 1'b0};
        end
    end

    assign bcd = shift_reg[SHIFT_W-1:BCD_ITER];

endmodule

// File: rtl/dht11_frame_processor.sv
// dht11_frame_processor: captures 40-bit DHT11 frames on the rising edge of
// the controller's done, validates the checksum (optionally gated by the
// controller's valid), converts the integer humidity/temperature bytes to
// BCD and publishes them with a one-cycle strobe. Saturating counters track
// good, rejected and dropped (arrived while busy) frames.
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   dht_data_out, valid  - controller frame and its valid flag
//   done                 - controller frame-complete (rising edge used)
//   hum_bcd, temp_bcd    - published BCD integer parts
//   hum_dec, temp_dec    - published raw decimal bytes
//   out_valid            - one-cycle strobe on publish
//   frame_err            - one-cycle strobe on reject
//   busy                 - high whenever the FSM is not idle
//   ok_cnt, err_cnt, drop_cnt - saturating statistics
module dht11_frame_processor
    import dht11_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter bit USE_CTRL_VALID = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [39:0]       dht_data_out,
    input  logic              valid,
    input  logic              done,
    output logic [11:0]       hum_bcd,
    output logic [11:0]       temp_bcd,
    output logic [7:0]        hum_dec,
    output logic [7:0]        temp_dec,
    output logic              out_valid,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       ITER_LAST = 4'(BCD_ITER - 1);

    logic              done_q_reg;
    logic              done_rise;
    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [39:0]       frame_reg;
    logic              valid_reg;
    logic [3:0]        iter_reg;
    logic              frame_good;
    logic              bcd_load;
    logic              bcd_step;
    logic [BCD_W-1:0]  hum_conv;
    logic [BCD_W-1:0]  temp_conv;

    assign done_rise = done & ~done_q_reg;

    assign frame_good = (frame_sum(frame_reg) == frame_reg[CSUM_LSB +: 8])
                     && (valid_reg || !USE_CTRL_VALID);

    assign bcd_load = (state_reg == ST_CHECK) && frame_good;
    assign bcd_step = (state_reg == ST_CONV);
    assign busy     = (state_reg != ST_IDLE);

    bin8_to_bcd_seq u_hum_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (bcd_load),
        .step (bcd_step),
        .bin  (frame_reg[HUM_INT_LSB +: 8]),
        .bcd  (hum_conv)
    );

    bin8_to_bcd_seq u_temp_bcd (
        .clk  (clk),
        .rst  (rst),
        .load (bcd_load),
        .step (bcd_step),
        .bin  (frame_reg[TEMP_INT_LSB +: 8]),
        .bcd  (temp_conv)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (done_rise) state_next = ST_CHECK;
            ST_CHECK:   state_next = frame_good ? ST_CONV : ST_REJECT;
            ST_CONV:    if (iter_reg == ITER_LAST) state_next = ST_PUBLISH;
            ST_PUBLISH: state_next = ST_IDLE;
            ST_REJECT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q_reg <= 1'b0;
            state_reg  <= ST_IDLE;
            frame_reg  <= '0;
            valid_reg  <= 1'b0;
            iter_reg   <= '0;
            hum_bcd    <= '0;
            temp_bcd   <= '0;
            hum_dec    <= '0;
            temp_dec   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            ok_cnt     <= '0;
            err_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            done_q_reg <= done;
            state_reg  <= state_next;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;

            if (done_rise) begin
                if (state_reg == ST_IDLE) begin
                    frame_reg <= dht_data_out;
                    valid_reg <= valid;
                end else if (drop_cnt != CNT_MAX) begin
                    // Frame arrived while busy: counted, not captured
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end

            case (state_reg)
                ST_CHECK: iter_reg <= '0;
                ST_CONV:  iter_reg <= iter_reg + 1'b1;
                ST_PUBLISH: begin
                    hum_bcd   <= hum_conv;
                    temp_bcd  <= temp_conv;
                    hum_dec   <= frame_reg[HUM_DEC_LSB +: 8];
                    temp_dec  <= frame_reg[TEMP_DEC_LSB +: 8];
                    out_valid <= 1'b1;
                    if (ok_cnt != CNT_MAX) ok_cnt <= ok_cnt + 1'b1;
                end
                ST_REJECT: begin
                    frame_err <= 1'b1;
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_frame_processor.sv
// Self-checking bench for dht11_frame_processor. Two instances share the
// stimulus: dut (controller valid honoured) and dut_nv (valid ignored).
module tb_dht11_frame_processor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [39:0] dht_data_out = '0;
    logic        valid = 1'b0;
    logic        done = 1'b0;

    logic [11:0] hum_bcd, temp_bcd, nv_hum_bcd, nv_temp_bcd;
    logic [7:0]  hum_dec, temp_dec, nv_hum_dec, nv_temp_dec;
    logic        out_valid, frame_err, busy, nv_out_valid, nv_frame_err, nv_busy;
    logic [7:0]  ok_cnt, err_cnt, drop_cnt, nv_ok_cnt, nv_err_cnt, nv_drop_cnt;

    dht11_frame_processor dut (
        .clk(clk), .rst(rst), .dht_data_out(dht_data_out), .valid(valid), .done(done),
        .hum_bcd(hum_bcd), .temp_bcd(temp_bcd), .hum_dec(hum_dec), .temp_dec(temp_dec),
        .out_valid(out_valid), .frame_err(frame_err), .busy(busy),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    dht11_frame_processor #(.CNT_W(8), .USE_CTRL_VALID(1'b0)) dut_nv (
        .clk(clk), .rst(rst), .dht_data_out(dht_data_out), .valid(valid), .done(done),
        .hum_bcd(nv_hum_bcd), .temp_bcd(nv_temp_bcd), .hum_dec(nv_hum_dec), .temp_dec(nv_temp_dec),
        .out_valid(nv_out_valid), .frame_err(nv_frame_err), .busy(nv_busy),
        .ok_cnt(nv_ok_cnt), .err_cnt(nv_err_cnt), .drop_cnt(nv_drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        bit         good;
        logic [11:0] hb;
        logic [11:0] tb;
        logic [7:0]  hd;
        logic [7:0]  td;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int          next_edge, next_edge_nv;
    int          exp_ok, exp_err, exp_drop;
    int          exp_ok_nv, exp_err_nv, exp_drop_nv;
    logic [11:0] pub_hb, pub_tb, exp_nv_hb, exp_nv_tb;
    logic [7:0]  pub_hd, pub_td;

    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int x;
        x = int'(v);
        return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb_q.delete();
        next_edge = 0; next_edge_nv = 0;
        exp_ok = 0; exp_err = 0; exp_drop = 0;
        exp_ok_nv = 0; exp_err_nv = 0; exp_drop_nv = 0;
        pub_hb = '0; pub_tb = '0; pub_hd = '0; pub_td = '0;
        exp_nv_hb = '0; exp_nv_tb = '0;
    endtask

    // Drive one frame with done held for 'hold' cycles, then one low cycle.
    task automatic send_frame(input logic [39:0] f, input logic v, input int hold);
        logic [7:0] s;
        bit   good, good_nv;
        int   e;
        exp_t x;
        s       = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        good_nv = (s == f[7:0]);
        good    = good_nv && v;
        e       = cyc + 1;
        if (e >= next_edge) begin
            x.good = good;
            x.hb   = to_bcd(f[39:32]);
            x.tb   = to_bcd(f[23:16]);
            x.hd   = f[31:24];
            x.td   = f[15:8];
            x.due  = e + (good ? 10 : 2);
            sb_q.push_back(x);
            next_edge = e + (good ? 11 : 3);
            if (good) exp_ok = sat_inc(exp_ok); else exp_err = sat_inc(exp_err);
        end else begin
            exp_drop = sat_inc(exp_drop);
        end
        if (e >= next_edge_nv) begin
            next_edge_nv = e + (good_nv ? 11 : 3);
            if (good_nv) begin
                exp_ok_nv = sat_inc(exp_ok_nv);
                exp_nv_hb = to_bcd(f[39:32]);
                exp_nv_tb = to_bcd(f[23:16]);
            end else begin
                exp_err_nv = sat_inc(exp_err_nv);
            end
        end else begin
            exp_drop_nv = sat_inc(exp_drop_nv);
        end
        $display("frame 0x%010h valid=%0b at cycle %0d", f, v, cyc);
        dht_data_out = f;
        valid        = v;
        done         = 1'b1;
        tick(hold);
        done = 1'b0;
        tick(1);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ok_cnt"},   32'(ok_cnt),   32'(exp_ok));
        check({tag, "_err_cnt"},  32'(err_cnt),  32'(exp_err));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hum_bcd"},   32'(hum_bcd),   32'd0);
        check({tag, "_temp_bcd"},  32'(temp_bcd),  32'd0);
        check({tag, "_hum_dec"},   32'(hum_dec),   32'd0);
        check({tag, "_temp_dec"},  32'(temp_dec),  32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_ok_cnt"},    32'(ok_cnt),    32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
        check({tag, "_drop_cnt"},  32'(drop_cnt),  32'd0);
    endtask

    // Scoreboard monitor: sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (out_valid || frame_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 32'({out_valid, frame_err}), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("strobe_kind", 32'({out_valid, frame_err}), e.good ? 32'd2 : 32'd1);
                    check("strobe_cycle", 32'(cyc), 32'(e.due));
                    if (e.good) begin
                        pub_hb = e.hb; pub_tb = e.tb; pub_hd = e.hd; pub_td = e.td;
                    end
                    check("hum_bcd",  32'(hum_bcd),  32'(pub_hb));
                    check("temp_bcd", 32'(temp_bcd), 32'(pub_tb));
                    check("hum_dec",  32'(hum_dec),  32'(pub_hd));
                    check("temp_dec", 32'(temp_dec), 32'(pub_td));
                    $display("strobe %s at cycle %0d hum_bcd=%03h temp_bcd=%03h",
                             e.good ? "out_valid" : "frame_err", cyc, hum_bcd, temp_bcd);
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                check("missing_strobe", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b1;
        tick(2);

        // Good frame, done held 2 cycles (only the rising edge counts)
        send_frame(40'h37_00_1A_05_56, 1'b1, 2);
        check("busy_during_conv", 32'(busy), 32'd1);
        tick(12);
        check_counters("good");

        // Checksum error: outputs must hold the previous publish
        send_frame(40'hAA_0F_C4_00_7F, 1'b1, 1);
        tick(6);
        check_counters("csum_err");

        // Boundary value, then a frame accepted exactly on return to IDLE
        send_frame(40'hFF_00_00_00_FF, 1'b1, 1);
        tick(9);
        send_frame(40'h63_02_64_03_CC, 1'b1, 1);
        tick(12);
        check_counters("boundary");

        // Controller valid gating
        send_frame(40'h37_00_1A_05_56, 1'b0, 1);
        tick(12);
        check_counters("gating");
        check("nv_ok_cnt",   32'(nv_ok_cnt),   32'(exp_ok_nv));
        check("nv_err_cnt",  32'(nv_err_cnt),  32'(exp_err_nv));
        check("nv_hum_bcd",  32'(nv_hum_bcd),  32'(exp_nv_hb));
        check("nv_temp_bcd", 32'(nv_temp_bcd), 32'(exp_nv_tb));

        // Overrun: second rise 4 cycles after the first
        send_frame(40'h37_00_1A_05_56, 1'b1, 1);
        tick(2);
        send_frame(40'h11_11_11_11_44, 1'b1, 1);
        tick(12);
        check_counters("overrun");
        check("overrun_drop_is_1", 32'(drop_cnt), 32'd1);
        check("nv_drop_cnt", 32'(nv_drop_cnt), 32'(exp_drop_nv));

        // 300 bad frames saturate err_cnt
        for (int i = 0; i < 300; i++) begin
            send_frame(40'hAA_0F_C4_00_7F, 1'b1, 1);
            tick(1);
        end
        tick(6);
        check_counters("saturate");
        check("err_cnt_sat_255", 32'(err_cnt), 32'd255);

        // Reset during cycle N+5 of a good frame
        send_frame(40'h37_00_1A_05_56, 1'b1, 1);
        tick(4);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_reset");
        tick(2);
        rst = 1'b1;
        tick(14);
        check_all_zero("after_reset");

        // Recovery frame converts normally
        send_frame(40'h37_00_1A_05_56, 1'b1, 1);
        tick(12);
        check_counters("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
